// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one "101" Mealy detector across CHANNELS serial streams.
// Each stream keeps its detector state in a bank; matches are tagged and counted per channel.
module seq_det_scheduler #(
  parameter  int CHANNELS  = 4,
  parameter  int CNT_WIDTH = 8,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHANNELS-1:0]  ch_valid,
  input  logic [CHANNELS-1:0]  ch_data,
  output logic [CHANNELS-1:0]  ch_ready,
  input  logic [CHANNELS-1:0]  ch_en,
  output logic                 match_valid,
  output logic [CH_W-1:0]      match_ch,
  input  logic [CH_W-1:0]      cnt_sel,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] match_cnt
);

  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10} state_e;

  logic [CHANNELS-1:0]                elig, gnt;
  logic [CH_W-1:0]                    gnt_idx, ptr_q, ptr_d;
  logic                               xfer, d_bit, hit;
  logic [1:0]                         cur_st, nxt_st;
  logic [CHANNELS-1:0][1:0]           bank_q, bank_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                               match_valid_q;
  logic [CH_W-1:0]                    match_ch_q, match_ch_d;

  assign elig = ch_valid & ch_en;

  // Rotating priority search starting at the pointer, wrapping past CHANNELS-1.
  always_comb begin : arb
    int j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    xfer    = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      j = int'(ptr_q) + i;
      if (j >= CHANNELS) j = j - CHANNELS;
      if (!xfer && elig[j]) begin
        xfer    = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = CH_W'(j);
      end
    end
  end

  assign ch_ready = rst ? '0 : gnt;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (gnt_idx == CH_W'(CHANNELS-1)) ? '0 : gnt_idx + CH_W'(1);
  end

  // Shared engine; encoding 11 falls into the default arm and behaves as S0.
  always_comb begin
    cur_st = bank_q[gnt_idx];
    d_bit  = ch_data[gnt_idx];
    nxt_st = S0;
    hit    = 1'b0;
    case (cur_st)
      S1:      nxt_st = d_bit ? S1 : S2;
      S2: begin
        nxt_st = d_bit ? S1 : S0;
        hit    = d_bit & xfer;
      end
      default: nxt_st = d_bit ? S1 : S0;
    endcase
  end

  always_comb begin
    bank_d = bank_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!ch_en[k])   bank_d[k] = S0;
      else if (gnt[k]) bank_d[k] = nxt_st;
    end
  end

  // Clear beats a coincident match on the same channel.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cnt_clr && cnt_sel == CH_W'(k))
        cnt_d[k] = '0;
      else if (hit && gnt[k] && cnt_q[k] != '1)
        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    match_cnt = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (cnt_sel == CH_W'(k)) match_cnt = cnt_q[k];
  end

  assign match_ch_d = hit ? gnt_idx : match_ch_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q         <= '0;
      bank_q        <= '0;
      cnt_q         <= '0;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
    end else begin
      ptr_q         <= ptr_d;
      bank_q        <= bank_d;
      cnt_q         <= cnt_d;
      match_valid_q <= hit;
      match_ch_q    <= match_ch_d;
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;

endmodule

// File: doc/seq_det_scheduler.md
Name: seq_det_scheduler

Overview:
Time-multiplexes one shared "101" Mealy detector engine across CHANNELS independent serial bit streams. Each stream is a requester with a valid/ready handshake. A round-robin arbiter grants one bit per cycle. A per-channel state bank preserves each stream's detector context between grants. The block reports tagged match pulses and keeps per-channel saturating match counters, which software reads through a select port.

Parameters:
CHANNELS, 4, number of serial requester channels (>=2)
CNT_WIDTH, 8, width of each per-channel saturating match counter
CH_W (localparam), clog2(CHANNELS), channel index width

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
ch_valid  input  CHANNELS  per-channel bit-valid
ch_data  input  CHANNELS  per-channel serial data bit
ch_ready  output  CHANNELS  one-hot grant; transfer when ch_valid[k] & ch_ready[k]
ch_en  input  CHANNELS  channel enable; low = channel idle and context cleared
match_valid  output  1  registered one-cycle match pulse
match_ch  output  CH_W  channel that produced match_valid
cnt_sel  input  CH_W  counter read/clear select
cnt_clr  input  1  clear counter[cnt_sel] at next edge
match_cnt  output  CNT_WIDTH  counter[cnt_sel], combinational read

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high. While rst=1:
  - all state_bank entries = S0
  - rr pointer = 0
  - match_valid = 0, match_ch = 0
  - all counters = 0
  - ch_ready = 0
- Eligibility: eligible[k] = ch_valid[k] & ch_en[k].
- Arbiter, combinational grant:
  - Search starts at the rr pointer and proceeds upward with wrap-around.
  - The first eligible channel gets ch_ready[k]=1; all others get 0. No eligible channel means ch_ready=0.
  - ch_ready never asserts for a channel with ch_en=0.
  - On a transfer by channel k, rr pointer <= (k+1) mod CHANNELS. With no transfer, the pointer holds.
- Shared engine, per-channel state in 2-bit encoding (S0=00, S1=01, S2=10; 11 is illegal and is treated as S0). Transitions for granted channel k with bit d, all without output unless noted:
  - S0: d=1 -> S1; d=0 -> S0
  - S1: d=0 -> S2; d=1 -> S1
  - S2: d=1 -> S1 with match; d=0 -> S0
- Detection is overlapping: stream 10101 yields two matches.
- Only state_bank[k] of the granted channel updates at the edge; non-granted entries hold.
- Latency: a match-producing transfer at edge N gives match_valid=1 and match_ch=k during the cycle after edge N, for exactly one cycle unless the next transfer also matches.
- No match in a cycle means match_valid=0 and match_ch holds its last value.
- Back-to-back grants to the same channel are legal when it is the sole eligible channel. Its state updates every edge, so there is no hazard.
- Channel disable: while ch_en[k]=0, state_bank[k] is forced to S0 each edge (synchronous clear). Partial patterns are lost. A disabled channel's counter is not cleared.
- Counters:
  - On a match for channel k, counter[k] increments, saturating at 2^CNT_WIDTH-1 with no wrap.
  - cnt_clr=1 clears counter[cnt_sel] at the edge.
  - If clear and a match on the same channel occur at the same edge, clear wins and the result is 0.
  - Clear of channel j and a match on channel k≠j at the same edge both take effect.
- Out-of-range cnt_sel (CHANNELS not a power of 2): match_cnt reads 0 and cnt_clr is ignored.
- Reset mid-stream: all context is lost immediately. Detection restarts from S0 after rst deasserts.

Test Plan:
1. Single stream: ch_en=4'b0001, ch0 sends 1,0,1,0,1 on consecutive cycles -> match_valid=1 with match_ch=0 in the cycle after the 3rd bit and after the 5th bit; match_cnt (cnt_sel=0) = 2.
2. Round-robin fairness: all 4 channels enabled and continuously valid, each sending 1,0,1 -> ch_ready cycles 0001,0010,0100,1000,... The 12 transfers produce 4 matches on the 9th-12th transfers with match_ch=0,1,2,3 in order.
3. Context isolation: ch0 sends 1,0; ch1 sends 1; ch0 sends 1 -> no match after ch1's bit; match with match_ch=0 after ch0's final bit.
4. Disable mid-pattern: ch2 sends 1,0; ch_en[2]=0 for one cycle; ch2 sends 1 -> no match; ch_ready[2]=0 while disabled; counter[2] unchanged.
5. Saturation/clear with CNT_WIDTH=2: ch1 produces 5 matches -> match_cnt=3. A further match coincident with cnt_clr (cnt_sel=1) -> match_cnt=0 next cycle.
6. Async reset: assert rst between edges while ch0 is in S2 -> match_valid, match_ch, ch_ready and counters read 0 immediately. After release, ch0 sends 1 -> no match; 0,1 -> match.
